// File: rtl/complex_counter_pkg.sv
// complex_counter_pkg: shared mode constants, checker states and the 3-bit counter step function.
package complex_counter_pkg;
    localparam int  CNT_W     = 3;
    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;
    typedef enum logic [1:0] {IDLE, ACQUIRE, TRACK, LOCKED} chk_state_t;
    function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] value, input logic mode);
        logic [CNT_W-1:0] b;
        b = {value[2], value[2] ^ value[1], value[2] ^ value[1] ^ value[0]};
        b = (mode == MODE_GRAY ? b : value) + 3'd1;
        return mode == MODE_GRAY ? b ^ (b >> 1) : b;
    endfunction
endpackage

// File: rtl/count_predictor.sv
// count_predictor: combinational next legal count for the binary/Gray counter.
import complex_counter_pkg::*;
module count_predictor (
    input  logic [CNT_W-1:0] prev_count,
    input  logic             prev_mode,
    output logic [CNT_W-1:0] expected_next
);
    assign expected_next = next_count(prev_count, prev_mode);
endmodule

// File: rtl/count_sequence_checker.sv
// count_sequence_checker: locks onto the counter stream and flags/counts sequence violations.
// Optional SEQ_CHECK_HIST_EN adds bad_value/bad_expected capture of the last violation.
import complex_counter_pkg::*;
module count_sequence_checker #(
    parameter int WIDTH     = 3,
    parameter int ERR_CNT_W = 8,
    parameter int LOCK_N    = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear_err,
    input  logic [WIDTH-1:0]     count,
    input  logic                 mode,
    output logic                 locked,
    output logic                 seq_error,
    output logic                 mode_change,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_CNT_W-1:0] error_count
`ifdef SEQ_CHECK_HIST_EN
    ,
    output logic [WIDTH-1:0]     bad_value,
    output logic [WIDTH-1:0]     bad_expected
`endif
);
    chk_state_t     state;
    logic [WIDTH-1:0] prev_count, pred;
    logic           prev_mode;
    logic [3:0]     good_cnt;
    logic           legal;
    count_predictor u_pred (.prev_count(prev_count), .prev_mode(prev_mode), .expected_next(pred));
    assign legal = count == pred;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            prev_count  <= '0;
            prev_mode   <= MODE_BIN;
            good_cnt    <= '0;
            locked      <= 1'b0;
            seq_error   <= 1'b0;
            mode_change <= 1'b0;
            expected    <= '0;
            error_count <= '0;
`ifdef SEQ_CHECK_HIST_EN
            bad_value    <= '0;
            bad_expected <= '0;
`endif
        end else begin
            seq_error   <= 1'b0;
            mode_change <= 1'b0;
            if (clear_err) error_count <= '0;
            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else if (state == IDLE) begin
                state <= ACQUIRE;
            end else begin
                // every judged sample (and the acquire sample) becomes the new base
                prev_count <= count;
                prev_mode  <= mode;
                expected   <= next_count(count, mode);
                if (state == ACQUIRE) begin
                    good_cnt <= '0;
                    state    <= TRACK;
                end else begin
                    mode_change <= mode != prev_mode;
                    if (legal) begin
                        if (state == TRACK) begin
                            good_cnt <= good_cnt + 4'd1;
                            if (good_cnt + 4'd1 == 4'(LOCK_N)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end else begin
                        good_cnt <= '0;
                        state    <= TRACK;
                        locked   <= 1'b0;
                        if (state == LOCKED) begin
                            seq_error   <= 1'b1;
                            error_count <= clear_err ? ERR_CNT_W'(1) : (&error_count ? error_count : error_count + 1'b1);
`ifdef SEQ_CHECK_HIST_EN
                            bad_value    <= count;
                            bad_expected <= pred;
`endif
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_count_sequence_checker.sv
// tb_count_sequence_checker: directed vectors with hand-computed expectations (2-bit error counter).
module tb_count_sequence_checker;
    logic       clock = 1'b0, reset = 1'b1, enable = 1'b0, clear_err = 1'b0, mode = 1'b0;
    logic [2:0] count = 3'd0;
    logic       locked, seq_error, mode_change;
    logic [2:0] expected;
    logic [1:0] error_count;
    int         checks = 0, fails = 0;
`ifdef SEQ_CHECK_HIST_EN
    logic [2:0] bad_value, bad_expected;
`endif
    count_sequence_checker #(.WIDTH(3), .ERR_CNT_W(2), .LOCK_N(2)) dut (
        .clock(clock), .reset(reset), .enable(enable), .clear_err(clear_err),
        .count(count), .mode(mode), .locked(locked), .seq_error(seq_error),
        .mode_change(mode_change), .expected(expected), .error_count(error_count)
`ifdef SEQ_CHECK_HIST_EN
        , .bad_value(bad_value), .bad_expected(bad_expected)
`endif
    );
    always #5 clock = ~clock;
    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic step(input logic [2:0] c, input logic m);
        @(negedge clock);
        count = c;
        mode  = m;
        @(posedge clock);
        #1;
    endtask
    initial begin
        #12;
        chk("rst_locked", locked, 0);
        chk("rst_seq_error", seq_error, 0);
        chk("rst_mode_change", mode_change, 0);
        chk("rst_expected", expected, 0);
        chk("rst_error_count", error_count, 0);
        @(negedge clock);
        reset  = 1'b0;
        enable = 1'b1;
        step(0, 0);
        chk("idle_to_acq_locked", locked, 0);
        step(0, 0);
        chk("acq_expected", expected, 1);
        step(1, 0);
        chk("bin_s2_locked", locked, 0);
        chk("bin_s2_expected", expected, 2);
        step(2, 0);
        chk("bin_s3_locked", locked, 1);
        for (int c = 3; c < 8; c++) begin
            step(3'(c), 0);
            chk("bin_run_seq_error", seq_error, 0);
        end
        chk("bin_after7_expected", expected, 0);
        step(0, 0);
        chk("wrap_seq_error", seq_error, 0);
        chk("wrap_locked", locked, 1);
        chk("wrap_expected", expected, 1);
        step(1, 0);
        step(2, 0);
        step(3, 1);
        chk("flip_mode_change", mode_change, 1);
        chk("flip_seq_error", seq_error, 0);
        chk("flip_locked", locked, 1);
        chk("flip_expected", expected, 2);
        step(2, 1);
        chk("flip_pulse_end", mode_change, 0);
        chk("gray_2_seq_error", seq_error, 0);
        step(6, 1); step(7, 1); step(5, 1); step(4, 1); step(0, 1); step(1, 1);
        chk("gray_expected_after_1", expected, 3);
        chk("gray_locked", locked, 1);
        chk("gray_error_count", error_count, 0);
        step(3, 1); step(2, 1);
        step(6, 0);
        chk("back_bin_mode_change", mode_change, 1);
        chk("back_bin_seq_error", seq_error, 0);
        chk("back_bin_expected", expected, 7);
        step(7, 0); step(0, 0); step(1, 0); step(2, 0); step(3, 0); step(4, 0); step(5, 0);
        chk("pre_inject_locked", locked, 1);
        step(3, 0);
        chk("inject_seq_error", seq_error, 1);
        chk("inject_error_count", error_count, 1);
        chk("inject_locked", locked, 0);
        chk("inject_expected", expected, 4);
`ifdef SEQ_CHECK_HIST_EN
        chk("hist_bad_value", bad_value, 3);
        chk("hist_bad_expected", bad_expected, 6);
`endif
        step(4, 0);
        chk("inject_pulse_end", seq_error, 0);
        chk("relock_s1_locked", locked, 0);
        step(5, 0);
        chk("relock_locked", locked, 1);
        step(6, 0);
        step(2, 0);
        chk("err2_count", error_count, 2);
        step(3, 0); step(4, 0);
        step(0, 0);
        chk("err3_count", error_count, 3);
        step(1, 0); step(2, 0);
        step(0, 0);
        chk("sat_count", error_count, 3);
        chk("sat_seq_error", seq_error, 1);
        step(1, 0); step(2, 0);
        clear_err = 1'b1;
        step(5, 0);
        chk("clear_with_err_count", error_count, 1);
        chk("clear_with_err_pulse", seq_error, 1);
        step(6, 0);
        chk("clear_alone_count", error_count, 0);
        chk("track_err_no_pulse", seq_error, 0);
        clear_err = 1'b0;
        step(7, 0);
        chk("post_clear_locked", locked, 1);
        step(2, 0); step(3, 0); step(4, 0);
        step(0, 0);
        chk("err_again_count", error_count, 2);
        step(1, 0); step(2, 0);
        chk("relock2_locked", locked, 1);
        enable = 1'b0;
        step(3, 0);
        chk("disable_locked", locked, 0);
        chk("disable_error_held", error_count, 2);
        enable = 1'b1;
        step(0, 0); step(0, 0); step(1, 0);
        chk("reacq_not_yet", locked, 0);
        step(2, 0);
        chk("reacq_locked", locked, 1);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_locked", locked, 0);
        chk("async_rst_error_count", error_count, 0);
        chk("async_rst_expected", expected, 0);
`ifdef SEQ_CHECK_HIST_EN
        chk("async_rst_bad_value", bad_value, 0);
`endif
        @(negedge clock);
        reset = 1'b0;
        step(0, 0);
        chk("post_rst_idle", locked, 0);
        step(0, 0);
        step(1, 0);
        chk("post_rst_s2_locked", locked, 0);
        step(2, 0);
        chk("post_rst_relocked", locked, 1);
        chk("post_rst_error_count", error_count, 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
